// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register master: FSM states, op-byte layout
// and the peripheral's register map.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  localparam int OP_RW_BIT   = 7;
  localparam int OP_ADDR_MSB = 2;
  localparam int OP_ADDR_LSB = 0;

  localparam logic [2:0] ADDR_CHIP_ID = 3'd0;
  localparam logic [2:0] ADDR_SW_LO   = 3'd1;
  localparam logic [2:0] ADDR_SW_HI   = 3'd2;
  localparam logic [2:0] ADDR_LED_LO  = 3'd3;
  localparam logic [2:0] ADDR_LED_HI  = 3'd4;

  localparam logic [7:0] CHIP_ID = 8'h07;

  // Reads carry a zero data byte so the peripheral sees a clean dummy byte.
  function automatic logic [15:0] build_frame(input logic rd, input logic [2:0] addr,
                                              input logic [7:0] wdata);
    logic [7:0] op;
    op = 8'h00;
    op[OP_RW_BIT] = rd;
    op[OP_ADDR_MSB:OP_ADDR_LSB] = addr;
    return {op, (rd ? 8'h00 : wdata)};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master; pre_tick fires one cycle before tick
// so the caller can leave a state a cycle early.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(CLK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick     = en && (cnt == CNT_W'(CLK_DIV - 1));
  assign pre_tick = en && (cnt == CNT_W'(CLK_DIV - 2));

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator for two-byte register transactions. Define
// SPI_REG_MASTER_LOOPBACK_EN to receive the internal mosi instead of the miso pin.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_read,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  state_t      state;
  logic [15:0] tx_shift;
  logic [15:0] rx_shift;
  logic [3:0]  bit_cnt;
  logic [15:0] frame;
  logic        tick;
  logic        pre_tick;
  logic        rx_bit;

  assign busy      = (state != ST_IDLE);
  assign req_ready = (state == ST_IDLE) && !rst;
  assign frame     = build_frame(req_read, req_addr, req_wdata);

`ifdef SPI_REG_MASTER_LOOPBACK_EN
  assign rx_bit = mosi;
`else
  assign rx_bit = miso;
`endif

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // RECOVER leaves on pre_tick so a held request is accepted exactly one frame period later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      tx_shift  <= 16'h0000;
      rx_shift  <= 16'h0000;
      bit_cnt   <= 4'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            tx_shift <= frame;
            mosi     <= frame[15];
            cs_n     <= 1'b0;
            bit_cnt  <= 4'd0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[14:0], rx_bit};
            end else begin
              sclk     <= 1'b0;
              tx_shift <= {tx_shift[14:0], 1'b0};
              mosi     <= tx_shift[14];
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                state <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx_shift[7:0];
            state     <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (pre_tick) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master: a behavioural SPI register peripheral plus a
// byte-array reference model of the register map.
module tb_spi_reg_master;
  import spi_reg_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int FRAME_LAT = 33 * CLK_DIV;
  localparam int FRAME_PER = 34 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_read = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso = 1'b0;
  logic       cs_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_reg_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_read  (req_read),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n)
  );

  // Peripheral: op byte then data byte; a write commits only if all 16 bits arrived.
  logic [15:0] sw_reg = 16'h0000;
  logic [15:0] led_reg = 16'h0000;
  logic [15:0] sl_in = 16'h0000;
  int          sl_cnt = 0;
  logic [7:0]  sl_resp = 8'h00;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;

  function automatic logic [7:0] periph_read(input logic [2:0] a);
    case (a)
      ADDR_CHIP_ID: return 8'h07;
      ADDR_SW_LO:   return sw_reg[7:0];
      ADDR_SW_HI:   return sw_reg[15:8];
      ADDR_LED_LO:  return led_reg[7:0];
      ADDR_LED_HI:  return led_reg[15:8];
      default:      return 8'h00;
    endcase
  endfunction

  always @(sclk or cs_n) begin
    if (prev_cs === 1'b1 && cs_n === 1'b0) begin
      sl_cnt  = 0;
      sl_in   = 16'h0000;
      sl_resp = 8'h00;
      miso    = 1'b0;
    end
    if (cs_n === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) begin
      sl_in  = {sl_in[14:0], mosi};
      sl_cnt = sl_cnt + 1;
      if (sl_cnt == 8) sl_resp = sl_in[7] ? periph_read(sl_in[2:0]) : 8'h00;
    end
    if (cs_n === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0 && sl_cnt >= 8 && sl_cnt < 16)
      miso = sl_resp[15-sl_cnt];
    if (prev_cs === 1'b0 && cs_n === 1'b1) begin
      if (sl_cnt == 16 && !sl_in[15]) begin
        case (sl_in[10:8])
          ADDR_LED_LO: led_reg[7:0]  = sl_in[7:0];
          ADDR_LED_HI: led_reg[15:8] = sl_in[7:0];
          default: ;
        endcase
      end
      miso = 1'b0;
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  // Monitors: accept times, response pulses, and the length of each cs_n-high gap.
  int cyc = 0;
  int rsp_seen = 0;
  int cs_hi_run = 0;
  int last_gap = 0;
  int acc_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (req_valid === 1'b1 && req_ready === 1'b1) acc_q.push_back(cyc);
    if (rsp_valid === 1'b1) rsp_seen++;
    if (cs_n === 1'b1) cs_hi_run++;
    else begin
      if (cs_hi_run > 0) last_gap = cs_hi_run;
      cs_hi_run = 0;
    end
  end

  // Reference model: one byte per register address.
  logic [7:0] model_regs [8];

  function automatic logic [7:0] model_rdata(input logic rd, input logic [2:0] a,
                                             input logic [7:0] wd);
`ifdef SPI_REG_MASTER_LOOPBACK_EN
    return rd ? 8'h00 : wd;
`else
    return rd ? model_regs[a] : 8'h00;
`endif
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [7:0] wd);
    if (a == 3'd3 || a == 3'd4) model_regs[a] = wd;
  endtask

  task automatic set_switches(input logic [15:0] v);
    sw_reg        = v;
    model_regs[1] = v[7:0];
    model_regs[2] = v[15:8];
  endtask

  task automatic do_txn(input logic rd, input logic [2:0] a, input logic [7:0] wd,
                        output logic [7:0] rdata, output logic [15:0] frame, output int lat);
    int g;
    @(negedge clk);
    req_valid = 1'b1;
    req_read  = rd;
    req_addr  = a;
    req_wdata = wd;
    g = 0;
    while (req_ready !== 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_read  = 1'($urandom_range(1));
    req_addr  = 3'($urandom_range(7));
    req_wdata = 8'($urandom_range(255));
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL txn_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
    end
    rdata = rsp_rdata;
    frame = sl_in;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
    model_regs[0] = 8'h07;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (cs_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n: got %b want 1", cs_n); end
    if (sclk !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi: got %b want 0", mosi); end
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_in_rst: got %b want 0", req_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_chip_id();
    logic [7:0] rd;
    logic [15:0] fr;
    int lat;
    do_txn(1'b1, ADDR_CHIP_ID, 8'h5A, rd, fr, lat);
    checks += 4;
    if (fr !== 16'h8000) begin errors++; $display("[TB] FAIL chip_id_frame: got %h want 8000", fr); end
    if (rd !== 8'h07) begin errors++; $display("[TB] FAIL chip_id_rdata: got %h want 07", rd); end
    if (lat !== FRAME_LAT) begin errors++; $display("[TB] FAIL chip_id_latency: got %0d want %0d", lat, FRAME_LAT); end
    if (cs_n !== 1'b1) begin errors++; $display("[TB] FAIL chip_id_cs_rise: got %b want 1", cs_n); end
    @(posedge clk);
    #1;
    checks += 3;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL chip_id_pulse_width: got %b want 0", rsp_valid); end
    if (rsp_rdata !== 8'h07) begin errors++; $display("[TB] FAIL chip_id_rdata_hold: got %h want 07", rsp_rdata); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL chip_id_busy_recover: got %b want 1", busy); end
  endtask

  task automatic test_switches();
    logic [7:0] rd;
    logic [15:0] fr;
    int lat;
    set_switches(16'hBEEF);
    do_txn(1'b1, ADDR_SW_LO, 8'h00, rd, fr, lat);
    checks++;
    if (rd !== 8'hEF) begin errors++; $display("[TB] FAIL sw_lo_rdata: got %h want ef", rd); end
    do_txn(1'b1, ADDR_SW_HI, 8'h00, rd, fr, lat);
    checks += 2;
    if (rd !== 8'hBE) begin errors++; $display("[TB] FAIL sw_hi_rdata: got %h want be", rd); end
    if (fr !== 16'h8200) begin errors++; $display("[TB] FAIL sw_hi_frame: got %h want 8200", fr); end
  endtask

  task automatic test_write_read();
    logic [7:0] rd;
    logic [7:0] exp;
    logic [15:0] fr;
    int lat;
    exp = model_rdata(1'b0, ADDR_LED_LO, 8'hA5);
    do_txn(1'b0, ADDR_LED_LO, 8'hA5, rd, fr, lat);
    model_write(ADDR_LED_LO, 8'hA5);
    checks += 2;
    if (fr !== 16'h03A5) begin errors++; $display("[TB] FAIL write_frame: got %h want 03a5", fr); end
    if (rd !== exp) begin errors++; $display("[TB] FAIL write_rdata: got %h want %h", rd, exp); end
    exp = model_rdata(1'b1, ADDR_LED_LO, 8'hFF);
    do_txn(1'b1, ADDR_LED_LO, 8'hFF, rd, fr, lat);
    checks += 3;
    if (fr !== 16'h8300) begin errors++; $display("[TB] FAIL readback_frame: got %h want 8300", fr); end
    if (rd !== exp) begin errors++; $display("[TB] FAIL readback_rdata: got %h want %h", rd, exp); end
    if (led_reg !== 16'h00A5) begin errors++; $display("[TB] FAIL led_value: got %h want 00a5", led_reg); end
  endtask

  task automatic test_back_to_back();
    int g;
    int rsp0;
    acc_q.delete();
    rsp0 = rsp_seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_read  = 1'b1;
    req_addr  = ADDR_CHIP_ID;
    g = 0;
    while (acc_q.size() < 3 && g < 2000) begin
      @(negedge clk);
      #1;
      g++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    g = 0;
    while (rsp_seen - rsp0 < 3 && g < 1000) begin
      @(posedge clk);
      g++;
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (acc_q.size() != 3) begin
      errors++;
      $display("[TB] FAIL b2b_accepts: got %0d want 3", acc_q.size());
    end else begin
      checks += 2;
      if (acc_q[1] - acc_q[0] != FRAME_PER) begin errors++; $display("[TB] FAIL b2b_spacing1: got %0d want %0d", acc_q[1] - acc_q[0], FRAME_PER); end
      if (acc_q[2] - acc_q[1] != FRAME_PER) begin errors++; $display("[TB] FAIL b2b_spacing2: got %0d want %0d", acc_q[2] - acc_q[1], FRAME_PER); end
    end
    checks += 3;
    if (rsp_seen - rsp0 != 3) begin errors++; $display("[TB] FAIL b2b_rsp_count: got %0d want 3", rsp_seen - rsp0); end
    if (last_gap != 4) begin errors++; $display("[TB] FAIL b2b_cs_gap: got %0d want 4", last_gap); end
    if (rsp_rdata !== model_rdata(1'b1, ADDR_CHIP_ID, 8'h00)) begin
      errors++;
      $display("[TB] FAIL b2b_rdata: got %h want %h", rsp_rdata, model_rdata(1'b1, ADDR_CHIP_ID, 8'h00));
    end
  endtask

  task automatic test_reset_mid();
    int g;
    int rsp0;
    @(negedge clk);
    req_valid = 1'b1;
    req_read  = 1'b0;
    req_addr  = ADDR_LED_HI;
    req_wdata = 8'h3F;
    g = 0;
    while (req_ready !== 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    g = 0;
    while (sl_cnt != 9 && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (sl_cnt != 9) begin errors++; $display("[TB] FAIL rst_mid_reach_rise9: got %0d rises want 9", sl_cnt); end
    rsp0 = rsp_seen;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks += 5;
    if (cs_n !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_cs_n: got %b want 1", cs_n); end
    if (sclk !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_sclk: got %b want 0", sclk); end
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_rsp_valid: got %b want 0", rsp_valid); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ready_in_rst: got %b want 0", req_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready_after: got %b want 1", req_ready); end
    repeat (200) @(posedge clk);
    #1;
    checks += 2;
    if (rsp_seen != rsp0) begin errors++; $display("[TB] FAIL rst_mid_no_rsp: got %0d pulses want 0", rsp_seen - rsp0); end
    if (led_reg !== {model_regs[4], model_regs[3]}) begin
      errors++;
      $display("[TB] FAIL rst_mid_led: got %h want %h", led_reg, {model_regs[4], model_regs[3]});
    end
  endtask

  task automatic test_random();
    logic [7:0] rd;
    logic [7:0] exp;
    logic [15:0] fr;
    logic [15:0] exp_fr;
    logic op_rd;
    logic [2:0] a;
    logic [7:0] wd;
    int lat;
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) set_switches(16'($urandom_range(65535)));
      op_rd  = 1'($urandom_range(1));
      a      = 3'($urandom_range(7));
      wd     = 8'($urandom_range(255));
      exp    = model_rdata(op_rd, a, wd);
      exp_fr = {op_rd, 4'b0000, a, (op_rd ? 8'h00 : wd)};
      do_txn(op_rd, a, wd, rd, fr, lat);
      if (!op_rd) model_write(a, wd);
      checks += 3;
      if (rd !== exp) begin errors++; $display("[TB] FAIL rand_rdata[%0d]: got %h want %h", i, rd, exp); end
      if (fr !== exp_fr) begin errors++; $display("[TB] FAIL rand_frame[%0d]: got %h want %h", i, fr, exp_fr); end
      if (lat !== FRAME_LAT) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d want %0d", i, lat, FRAME_LAT); end
    end
    checks++;
    if (led_reg !== {model_regs[4], model_regs[3]}) begin
      errors++;
      $display("[TB] FAIL rand_led: got %h want %h", led_reg, {model_regs[4], model_regs[3]});
    end
  endtask

`ifdef SPI_REG_MASTER_LOOPBACK_EN
  task automatic test_loopback();
    logic [7:0] rd;
    logic [15:0] fr;
    int lat;
    do_txn(1'b0, ADDR_LED_LO, 8'h3C, rd, fr, lat);
    model_write(ADDR_LED_LO, 8'h3C);
    checks++;
    if (rd !== 8'h3C) begin errors++; $display("[TB] FAIL loopback_write: got %h want 3c", rd); end
    do_txn(1'b1, ADDR_CHIP_ID, 8'hFF, rd, fr, lat);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("[TB] FAIL loopback_read: got %h want 00", rd); end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting spi_reg_master bench");
    test_reset();
    test_chip_id();
    test_switches();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SPI_REG_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

SPI initiator that runs two-byte register transactions against the board's SPI register peripheral (chip ID, switches, LEDs). It accepts one read or write request through a valid/ready handshake and serialises it as an SPI mode-0 frame. It returns the byte clocked in during the second frame byte. It sits on the host side of the SPI link.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles. Legal range is ≥2.
- `clk` input, 1 bit: system clock. This is the only clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: high only in IDLE with `rst` low.
- `req_read` input, 1 bit: 1 = read, 0 = write.
- `req_addr` input, 3 bits: register address A2..A0.
- `req_wdata` input, 8 bits: write data. Ignored for reads.
- `rsp_valid` output, 1 bit: one-cycle pulse at the end of each transaction.
- `rsp_rdata` output, 8 bits: second-byte MISO data. Held until the next `rsp_valid`.
- `busy` output, 1 bit: high in every state except IDLE.
- `sclk` output, 1 bit: SPI clock, idles low.
- `mosi` output, 1 bit: SPI data out, MSB first.
- `miso` input, 1 bit: SPI data in.
- `cs_n` output, 1 bit: chip select, active low.

## Operation
- Frame layout, 16 bits, MSB first:
  - Byte 1 = {`req_read`, 4'b0000, `req_addr`}.
  - Byte 2 = `req_wdata` for a write, 8'h00 for a read.
- Request acceptance:
  - A request is accepted on an edge where `req_valid && req_ready`.
  - The frame is latched into a 16-bit shift register at that edge.
  - Inputs are don't-care after acceptance.
- SPI mode 0:
  - `mosi` is valid before each SCLK rising edge.
  - `miso` is sampled on the SCLK rising edge.
  - `mosi` advances on the SCLK falling edge.
- Received bits shift into a 16-bit receive register. `rsp_rdata` takes bits [7:0], the second byte.
- A write also pulses `rsp_valid`. Its `rsp_rdata` is whatever the peripheral drove, and callers ignore it.
- States:
  - IDLE: on accept, go to SHIFT.
  - SHIFT: 32 half-periods, alternating rise and fall; after the 16th fall, go to HOLD.
  - HOLD: 1 half-period with `cs_n` low and `sclk` low; then go to RECOVER.
  - RECOVER: 1 half-period with `cs_n` high; then go to IDLE.
- Half-period tick: a counter 0..CLK_DIV-1, width `$clog2(CLK_DIV)`. It wraps to 0 on each tick and is cleared on accept.

## Timing
- Reset values: `cs_n`=1, `sclk`=0, `mosi`=0, `rsp_valid`=0, `rsp_rdata`=8'h00, `busy`=0, state IDLE.
- `req_ready`=0 while `rst` is high and becomes 1 in the first cycle after `rst` falls.
- Let E0 be the accept edge:
  - At E0: `cs_n`→0 and `mosi`→bit15.
  - SCLK rising edge k (k=1..16) occurs at E0+(2k−1)·CLK_DIV; the matching falling edge occurs at E0+2k·CLK_DIV.
  - At E0+33·CLK_DIV: `cs_n`→1, and `rsp_valid`=1 for exactly one cycle with `rsp_rdata` updated in the same edge.
  - `req_ready` reasserts at E0+34·CLK_DIV.
- Throughput is one transaction per 34·CLK_DIV cycles. A continuously held `req_valid` is accepted again exactly then.
- `req_valid` while busy: no effect and not queued.
- `rst` mid-transaction takes effect at the next edge:
  - All outputs go to their reset values, the frame is abandoned, and no `rsp_valid` is produced.
  - `cs_n` rising ends the peripheral's transaction.
- All SPI outputs are registered, so no glitches appear on `sclk` or `cs_n`.

## Configuration
- `SPI_REG_MASTER_LOOPBACK_EN` defined: the receive path samples the internal `mosi` instead of the `miso` pin, for bring-up without a peripheral.
  - A read returns 8'h00.
  - A write returns `req_wdata`.
  - All timing is unchanged.
- Not defined: the `miso` pin is sampled. This is the default build.

## Structure
- `spi_reg_pkg` holds:
  - The state enum.
  - Op-byte field positions: RW bit 7, address bits [2:0].
  - Address constants: ADDR_CHIP_ID=0, ADDR_SW_LO=1, ADDR_SW_HI=2, ADDR_LED_LO=3, ADDR_LED_HI=4.
  - CHIP_ID=8'h07.
- `spi_clk_div` sub-module, parameter `CLK_DIV`:
  - Produces a one-cycle `tick` every CLK_DIV cycles while enabled.
  - Holds its counter at 0 when disabled or in reset.
- Top-level FSM, shift registers and bit counter live in `spi_reg_master`.

## Test plan
All scenarios use a bench SPI slave model implementing the register map, with CLK_DIV=4.
- Read of ADDR_CHIP_ID → MOSI frame 8'h80, 8'h00; `rsp_rdata`=8'h07; `rsp_valid` 132 cycles after accept.
- Set switches=16'hBEEF, then read addresses 1 and 2 → `rsp_rdata`=8'hEF, then 8'hBE.
- Write address 3 with 8'hA5, then read address 3 → MOSI 8'h03, 8'hA5, then 8'h83, 8'h00; readback 8'hA5; LED model shows 16'h00A5.
- Hold `req_valid` high for three requests → accepts spaced exactly 136 cycles apart; `cs_n` high for 4 cycles between frames; one `rsp_valid` per frame.
- Assert `rst` at SCLK rising edge 9 of a write → next edge gives `cs_n`=1, `sclk`=0 and no `rsp_valid`; the slave LEDs are unchanged; `req_ready`=1 in the first cycle after `rst` deasserts.
- With `SPI_REG_MASTER_LOOPBACK_EN` defined, write 8'h3C → `rsp_rdata`=8'h3C; a read returns 8'h00.
